// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - execute/fetch requester, memory macro and power signals of the arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              ex_rd_req;
  logic              ex_wr_req;
  logic [ADDR_W-1:0] ex_addr;
  logic [DATA_W-1:0] ex_wdata;
  logic [DATA_W-1:0] ex_rdata;
  logic              ex_ack;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              powerdown;
  logic              asleep;

  // arbiter side
  modport slave (
    input  ex_rd_req, ex_wr_req, ex_addr, ex_wdata,
    output ex_rdata, ex_ack,
    input  if_req, if_addr,
    output if_rdata, if_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    input  powerdown,
    output asleep
  );

  // requesters, memory macro and power controller side
  modport master (
    output ex_rd_req, ex_wr_req, ex_addr, ex_wdata,
    input  ex_rdata, ex_ack,
    output if_req, if_addr,
    input  if_rdata, if_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    output powerdown,
    input  asleep
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter for a single-ported data memory, fixed 4-cycle access
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_DONE,
    ST_SLEEP
  } state_t;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("mem_port_arbiter: STARVE_LIMIT must be 1..15");
  end

  state_t            r_state;
  state_t            w_next_state;

  logic              r_win_if;
  logic              r_we;
  logic [DATA_W-1:0] r_ex_rdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic              r_ex_ack;
  logic              r_if_ack;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_asleep;

  logic              w_ex_pend;
  logic              w_fetch_first;
  logic              w_grant_ex;
  logic              w_grant_if;

  assign w_ex_pend = bus.ex_rd_req | bus.ex_wr_req;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] r_starve_cnt;

  assign w_fetch_first = (r_starve_cnt == LP_LIMIT);

  // Counts execute wins only while fetch is actually waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve_cnt <= 4'd0;
    end else if (w_grant_ex) begin
      r_starve_cnt <= bus.if_req ? (r_starve_cnt + 4'd1) : 4'd0;
    end else if (w_grant_if) begin
      r_starve_cnt <= 4'd0;
    end
  end
`else
  assign w_fetch_first = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_grant_ex   = 1'b0;
    w_grant_if   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.powerdown) begin
          w_next_state = ST_SLEEP;
        end else if (w_ex_pend && !(bus.if_req && w_fetch_first)) begin
          w_grant_ex   = 1'b1;
          w_next_state = ST_ACCESS;
        end else if (bus.if_req) begin
          w_grant_if   = 1'b1;
          w_next_state = ST_ACCESS;
        end
      end
      ST_ACCESS: w_next_state = ST_WAIT;
      ST_WAIT:   w_next_state = ST_DONE;
      ST_DONE:   w_next_state = ST_IDLE;
      ST_SLEEP: begin
        if (!bus.powerdown) begin
          w_next_state = ST_IDLE;
        end
      end
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_win_if    <= 1'b0;
      r_we        <= 1'b0;
      r_ex_rdata  <= '0;
      r_if_rdata  <= '0;
      r_ex_ack    <= 1'b0;
      r_if_ack    <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_asleep    <= 1'b0;
    end else begin
      r_mem_en <= w_grant_ex | w_grant_if;
      r_mem_we <= w_grant_ex & bus.ex_wr_req;
      r_asleep <= (w_next_state == ST_SLEEP);
      r_ex_ack <= (r_state == ST_WAIT) && !r_win_if;
      r_if_ack <= (r_state == ST_WAIT) && r_win_if;

      if (w_grant_ex) begin
        r_win_if    <= 1'b0;
        r_we        <= bus.ex_wr_req;
        r_mem_addr  <= bus.ex_addr;
        r_mem_wdata <= bus.ex_wdata;
      end else if (w_grant_if) begin
        r_win_if   <= 1'b1;
        r_we       <= 1'b0;
        r_mem_addr <= bus.if_addr;
      end

      if ((r_state == ST_WAIT) && !r_we) begin
        if (r_win_if) begin
          r_if_rdata <= bus.mem_rdata;
        end else begin
          r_ex_rdata <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.ex_rdata  = r_ex_rdata;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.ex_ack    = r_ex_ack;
  assign bus.if_ack    = r_if_ack;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.asleep    = r_asleep;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a behavioural memory macro
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        is_if;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_we     = 0;
  exp_t exp_q[$];

  logic [15:0] mem [0:255];
  bit          preloaded = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // synchronous memory macro: read data valid the cycle after mem_en
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h1000 + 16'(i);
      mem[8'hB4] <= 16'd45;
      preloaded  <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  // monitor: every ack must match the oldest expected completion
  always @(negedge clk) begin
    exp_t e;
    if (bus.mem_we) n_we++;
    if (bus.ex_ack && bus.if_ack) begin
      chk("dual_ack", 32'(2), 32'(1));
    end else if (bus.ex_ack || bus.if_ack) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", {31'd0, bus.if_ack}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("ack_id", {31'd0, bus.if_ack}, {31'd0, e.is_if});
        chk("ack_data", {16'd0, (bus.if_ack ? bus.if_rdata : bus.ex_rdata)}, {16'd0, e.data});
      end
    end
  end

  task automatic push(input logic is_if, input logic [15:0] d);
    exp_t e;
    e.is_if = is_if;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  // wait for all queued completions, then drop requests at the edge ending the last ack
  task automatic drain(input string nm, input int req_cyc);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 400) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk({nm, "_cycles"}, 32'(cyc), 32'(req_cyc));
    @(posedge clk);
    #1;
    bus.ex_rd_req = 1'b0;
    bus.ex_wr_req = 1'b0;
    bus.if_req    = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int we0;
    bus.ex_rd_req = 1'b0;
    bus.ex_wr_req = 1'b0;
    bus.ex_addr   = '0;
    bus.ex_wdata  = '0;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.powerdown = 1'b0;

    step();
    step();
    chk("rst_ex_rdata",  {16'd0, bus.ex_rdata}, 32'd0);
    chk("rst_if_rdata",  {16'd0, bus.if_rdata}, 32'd0);
    chk("rst_ex_ack",    {31'd0, bus.ex_ack}, 32'd0);
    chk("rst_if_ack",    {31'd0, bus.if_ack}, 32'd0);
    chk("rst_mem_en",    {31'd0, bus.mem_en}, 32'd0);
    chk("rst_mem_we",    {31'd0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr",  {24'd0, bus.mem_addr}, 32'd0);
    chk("rst_mem_wdata", {16'd0, bus.mem_wdata}, 32'd0);
    chk("rst_asleep",    {31'd0, bus.asleep}, 32'd0);
    rst_n = 1'b1;
    step();

    // reset asserted while a write to 0x10 is in ACCESS
    bus.ex_wr_req = 1'b1;
    bus.ex_addr   = 8'h10;
    bus.ex_wdata  = 16'hDEAD;
    step();
    chk("mid_rst_access_en", {31'd0, bus.mem_en}, 32'd1);
    chk("mid_rst_access_we", {31'd0, bus.mem_we}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_en",    {31'd0, bus.mem_en}, 32'd0);
    chk("mid_rst_mem_we",    {31'd0, bus.mem_we}, 32'd0);
    chk("mid_rst_mem_addr",  {24'd0, bus.mem_addr}, 32'd0);
    chk("mid_rst_mem_wdata", {16'd0, bus.mem_wdata}, 32'd0);
    step();
    bus.ex_wr_req = 1'b0;
    rst_n = 1'b1;
    repeat (4) step();
    chk("mid_rst_no_write", {16'd0, mem[8'h10]}, 32'h1010);
    chk("mid_rst_asleep",   {31'd0, bus.asleep}, 32'd0);

    // load from 0xB4 with cycle-exact handshake timing
    bus.ex_rd_req = 1'b1;
    bus.ex_addr   = 8'hB4;
    push(1'b0, 16'd45);
    step();
    chk("load_n1_mem_en",   {31'd0, bus.mem_en}, 32'd1);
    chk("load_n1_mem_we",   {31'd0, bus.mem_we}, 32'd0);
    chk("load_n1_mem_addr", {24'd0, bus.mem_addr}, 32'hB4);
    step();
    chk("load_n2_mem_en", {31'd0, bus.mem_en}, 32'd0);
    chk("load_n2_ex_ack", {31'd0, bus.ex_ack}, 32'd0);
    step();
    chk("load_n3_ex_ack",   {31'd0, bus.ex_ack}, 32'd1);
    chk("load_n3_ex_rdata", {16'd0, bus.ex_rdata}, 32'd45);
    step();
    bus.ex_rd_req = 1'b0;
    chk("load_n4_ex_ack", {31'd0, bus.ex_ack}, 32'd0);

    // store 54 to 0x0C, then fetch it back; ex_rdata keeps the load result
    we0 = n_we;
    bus.ex_wr_req = 1'b1;
    bus.ex_addr   = 8'h0C;
    bus.ex_wdata  = 16'd54;
    push(1'b0, 16'd45);
    drain("store", 4);
    bus.if_req  = 1'b1;
    bus.if_addr = 8'h0C;
    push(1'b1, 16'd54);
    drain("fetch", 4);
    chk("store_we_pulses", 32'(n_we - we0), 32'd1);
    chk("store_mem",       {16'd0, mem[8'h0C]}, 32'd54);
    chk("store_ex_rdata",  {16'd0, bus.ex_rdata}, 32'd45);

    // read and write requested together is a write
    bus.ex_rd_req = 1'b1;
    bus.ex_wr_req = 1'b1;
    bus.ex_addr   = 8'h20;
    bus.ex_wdata  = 16'h0077;
    push(1'b0, 16'd45);
    drain("rdwr", 4);
    chk("rdwr_mem", {16'd0, mem[8'h20]}, 32'h0077);

    // both requesters held continuously
`ifdef MEM_ARB_STARVE_GUARD_EN
    for (int k = 0; k < 10; k++) begin
      if ((k % 5) == 4) push(1'b1, 16'h1031);
      else              push(1'b0, 16'h1030);
    end
`else
    for (int k = 0; k < 6; k++) push(1'b0, 16'h1030);
`endif
    bus.ex_rd_req = 1'b1;
    bus.ex_addr   = 8'h30;
    bus.if_req    = 1'b1;
    bus.if_addr   = 8'h31;
`ifdef MEM_ARB_STARVE_GUARD_EN
    drain("both_guard", 40);
`else
    drain("both_strict", 24);
`endif

    // powerdown raised during WAIT of a fetch
    bus.if_req  = 1'b1;
    bus.if_addr = 8'h40;
    push(1'b1, 16'h1040);
    step();
    chk("pd_access", {31'd0, bus.mem_en}, 32'd1);
    step();
    bus.powerdown = 1'b1;
    bus.ex_rd_req = 1'b1;
    bus.ex_addr   = 8'h41;
    step();
    chk("pd_if_ack",      {31'd0, bus.if_ack}, 32'd1);
    chk("pd_done_asleep", {31'd0, bus.asleep}, 32'd0);
    step();
    bus.if_req = 1'b0;
    chk("pd_idle_asleep", {31'd0, bus.asleep}, 32'd0);
    step();
    chk("pd_asleep_rise", {31'd0, bus.asleep}, 32'd1);
    repeat (6) step();
    chk("pd_asleep_hold", {31'd0, bus.asleep}, 32'd1);
    chk("pd_no_grant",    {31'd0, bus.mem_en}, 32'd0);
    bus.powerdown = 1'b0;
    push(1'b0, 16'h1041);
    step();
    chk("pd_asleep_fall", {31'd0, bus.asleep}, 32'd0);
    drain("pd_wake", 4);

    repeat (3) step();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one single-ported 256x16 data memory between two requesters: the execute/store-back stage (loads and stores) and the fetch stage (reads only). Each granted access is sequenced through a fixed four-state cycle with a registered request/acknowledge handshake. The block honours the processor `powerdown` line by parking in a sleep state between accesses. It sits between `executeAndStoreBack`, the fetch unit and the synchronous data memory macro.

## Interface
- `ADDR_W`, 8, memory address width
- `DATA_W`, 16, data word width
- `STARVE_LIMIT`, 4, consecutive execute grants allowed while fetch waits (1..15)

- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `ex_rd_req`  in  1  execute load request, held until `ex_ack`
- `ex_wr_req`  in  1  execute store request, held until `ex_ack`
- `ex_addr`  in  ADDR_W  execute address
- `ex_wdata`  in  DATA_W  store data
- `ex_rdata`  out  DATA_W  load result, valid when `ex_ack`
- `ex_ack`  out  1  one-cycle completion pulse to execute
- `if_req`  in  1  fetch read request, held until `if_ack`
- `if_addr`  in  ADDR_W  fetch address
- `if_rdata`  out  DATA_W  fetch result, valid when `if_ack`
- `if_ack`  out  1  one-cycle completion pulse to fetch
- `mem_en`, `mem_we`  out  1 each  memory enable / write enable
- `mem_addr`  out  ADDR_W;  `mem_wdata`  out  DATA_W
- `mem_rdata`  in  DATA_W  memory read data, valid one cycle after `mem_en`
- `powerdown`  in  1  request to sleep
- `asleep`  out  1  high while in SLEEP

## Operation
- States: IDLE, ACCESS, WAIT, DONE, SLEEP. Reset -> IDLE.
- IDLE: if `powerdown`=1 -> SLEEP (overrides pending requests). Otherwise pick a winner, latch its id/addr/wdata/we, then -> ACCESS. No request -> stay.
- Default priority: execute over fetch. Execute with both `ex_rd_req` and `ex_wr_req` high is treated as a write.
- ACCESS: `mem_en`=1, `mem_we`=latched we, `mem_addr`/`mem_wdata` = latched values; -> WAIT.
- WAIT: `mem_en`=0. Capture `mem_rdata` into the winner's rdata register on reads only; -> DONE.
- DONE: winner's ack = 1 for this cycle only. Requests are ignored here. -> IDLE.
- Writes never alter `ex_rdata`. The non-winning rdata register holds its value.
- SLEEP: `asleep`=1, no grants. Exit to IDLE when `powerdown`=0.
- `powerdown` raised mid-access does not abort; it is acted on at the next IDLE.
- Reset asserted in any state: immediate IDLE, all outputs 0, counter 0. An access in ACCESS is dropped, and no ack is issued for it.

## Timing
- Reset values: `ex_rdata`=0, `if_rdata`=0, `ex_ack`=0, `if_ack`=0, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `asleep`=0.
- All outputs are registered.
- Request sampled high in IDLE at cycle N: `mem_en` high in N+1, rdata captured at end of N+2, ack high in N+3, IDLE in N+4.
- Fixed 4-cycle occupancy per access, with back-to-back grants every 4 cycles.
- The requester drops or changes its request at the edge ending its ack cycle. A held request is re-granted as a new access.
- `asleep` rises the cycle after IDLE samples `powerdown`=1. It falls the cycle after SLEEP samples `powerdown`=0.

## Configuration
- Macro: `MEM_ARB_STARVE_GUARD_EN`.
- **Defined:** a 4-bit counter tracks execute grants.
  - It increments on each execute grant made while `if_req`=1.
  - It clears on a fetch grant, or on an execute grant with `if_req`=0.
  - When the counter equals `STARVE_LIMIT` and both requesters are pending, fetch wins.
- **Undefined:** no counter; strict execute priority, so fetch can starve indefinitely.

## Test plan
- **Reset:** drive `rst`=0 mid-ACCESS of a write to 0x10 -> all outputs 0 next sample, no `ex_ack`, state IDLE.
- **Load:** preload mem[0xB4]=45; `ex_rd_req`, `ex_addr`=0xB4 at N -> `mem_en` at N+1, `ex_ack` with `ex_rdata`=45 at N+3, single-cycle pulse.
- **Store then fetch:** `ex_wr_req` to 0x0C with data 54, then `if_req` at 0x0C -> `mem_we`=1 once, `if_rdata`=54 on `if_ack`, `ex_rdata` unchanged.
- **Simultaneous requests, guard off:** `ex_rd_req`, `if_req` both held -> 6 consecutive `ex_ack`, no `if_ack`.
- **Simultaneous requests, guard on (`STARVE_LIMIT`=4):** both held continuously -> grant order E,E,E,E,F,E,E,E,E,F.
- **Powerdown:** raise `powerdown` during WAIT of a fetch -> `if_ack` still issued, `asleep`=1 the cycle after the following IDLE, pending `ex_rd_req` not granted until `powerdown`=0.
